// File: rtl/edge_window_sum.sv
// Moving-window summer for the edge-trigger datapath.
// Accepts one unsigned sample per strobe and reports the sum of the last W
// accepted samples, one cycle after each sample that leaves the window full.
// W is latched when the block leaves IDLE. Later changes to window_width_i
// are ignored until the next reset or clear.
// The sample buffer is never cleared. An entry is subtracted only after the
// fill phase has rewritten it, so old contents cannot reach the sum.
// SUM_W must be at least DIN_W + PTR_W, so a full window cannot overflow.
//
// Handshake: a sample is taken on a rising clk edge when enable_i and
// din_valid_i are both high, the block is past IDLE, and clear_i is low.
// The block is never busy, so there is no ready signal. sum_valid_o is a
// one-cycle pulse, and sum_o holds its value between pulses.
module edge_window_sum #(
  parameter int DIN_W = 14,
  parameter int SUM_W = 32,
  parameter int PTR_W = 8
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [PTR_W-1:0] window_width_i,
  input  logic [DIN_W-1:0] din_i,
  input  logic             din_valid_i,
  output logic [SUM_W-1:0] sum_o,
  output logic             sum_valid_o,
  output logic             full_o,
  output logic [PTR_W-1:0] fill_cnt_o,
  output logic [1:0]       state_dbg_o
);

  localparam int DEPTH = 1 << PTR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] wl;
  logic [PTR_W-1:0] wr_ptr;
  logic [SUM_W-1:0] acc_sum;
  logic [DIN_W-1:0] mem [DEPTH];

  logic             acc;
  logic             fill_done;
  logic [DIN_W-1:0] old_sample;
  logic [SUM_W-1:0] sum_next;
  logic [PTR_W-1:0] ptr_next;
  logic [PTR_W-1:0] fill_inc;

  assign state_dbg_o = state;

  // Accept decode, next running sum, and next write pointer.
  // The old entry is read here, before this cycle's write, so it is the
  // sample leaving the window.
  always_comb begin
    acc        = enable_i & din_valid_i & (state != IDLE);
    old_sample = mem[wr_ptr];
    fill_inc   = fill_cnt_o + PTR_W'(1);
    fill_done  = (state == FILL) && (fill_inc == wl);
    sum_next   = acc_sum + SUM_W'(din_i);
    if (state == RUN) begin
      sum_next = acc_sum + SUM_W'(din_i) - SUM_W'(old_sample);
    end
    ptr_next = wr_ptr + PTR_W'(1);
    if (wr_ptr == wl - PTR_W'(1)) begin
      ptr_next = '0;
    end
  end

  // Sample buffer: synchronous write of each accepted sample.
  always_ff @(posedge clk) begin
    if (acc && !clear_i && !reset_i) begin
      mem[wr_ptr] <= din_i;
    end
  end

  // Control FSM with registered sum, pulse, and fill outputs.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      wl          <= PTR_W'(1);
      wr_ptr      <= '0;
      acc_sum     <= '0;
      sum_o       <= '0;
      sum_valid_o <= 1'b0;
      full_o      <= 1'b0;
      fill_cnt_o  <= '0;
    end else if (clear_i) begin
      state       <= IDLE;
      wl          <= PTR_W'(1);
      wr_ptr      <= '0;
      acc_sum     <= '0;
      sum_o       <= '0;
      sum_valid_o <= 1'b0;
      full_o      <= 1'b0;
      fill_cnt_o  <= '0;
    end else begin
      sum_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_i) begin
            wl    <= (window_width_i == '0) ? PTR_W'(1) : window_width_i;
            state <= FILL;
          end
        end
        FILL: begin
          if (acc) begin
            acc_sum    <= sum_next;
            fill_cnt_o <= fill_inc;
            wr_ptr     <= ptr_next;
            if (fill_done) begin
              full_o      <= 1'b1;
              state       <= RUN;
              sum_o       <= sum_next;
              sum_valid_o <= 1'b1;
            end
          end
        end
        RUN: begin
          if (acc) begin
            acc_sum     <= sum_next;
            wr_ptr      <= ptr_next;
            sum_o       <= sum_next;
            sum_valid_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_window_sum.sv
// Bench for edge_window_sum. It uses directed and random steps. A queue
// holds the current window contents, and the expected sum is the plain
// arithmetic sum of that queue.
module tb_edge_window_sum;

  localparam int DIN_W = 14;
  localparam int SUM_W = 32;
  localparam int PTR_W = 8;

  logic             clk = 1'b0;
  logic             reset_i;
  logic             clear_i;
  logic             enable_i;
  logic [PTR_W-1:0] window_width_i;
  logic [DIN_W-1:0] din_i;
  logic             din_valid_i;
  logic [SUM_W-1:0] sum_o;
  logic             sum_valid_o;
  logic             full_o;
  logic [PTR_W-1:0] fill_cnt_o;
  logic [1:0]       state_dbg_o;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  // Reference model state
  bit               m_active;
  int               m_wl;
  logic [DIN_W-1:0] m_hist[$];
  logic             e_valid;
  logic [SUM_W-1:0] e_sum;

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout sim time limit reached");
    $fatal(1, "timeout");
  end

  edge_window_sum #(.DIN_W(DIN_W), .SUM_W(SUM_W), .PTR_W(PTR_W)) dut (
    .clk(clk),
    .reset_i(reset_i),
    .clear_i(clear_i),
    .enable_i(enable_i),
    .window_width_i(window_width_i),
    .din_i(din_i),
    .din_valid_i(din_valid_i),
    .sum_o(sum_o),
    .sum_valid_o(sum_valid_o),
    .full_o(full_o),
    .fill_cnt_o(fill_cnt_o),
    .state_dbg_o(state_dbg_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_wl     = 1;
    m_hist.delete();
    e_valid  = 1'b0;
    e_sum    = '0;
  endtask

  // One clock edge of the reference behaviour, using the inputs just driven.
  task automatic model_edge();
    if (clear_i) begin
      model_reset();
    end else if (!m_active) begin
      e_valid = 1'b0;
      if (enable_i) begin
        m_active = 1'b1;
        m_wl     = (window_width_i == 0) ? 1 : int'(window_width_i);
      end
    end else begin
      e_valid = 1'b0;
      if (enable_i && din_valid_i) begin
        m_hist.push_back(din_i);
        if (m_hist.size() > m_wl) void'(m_hist.pop_front());
        if (m_hist.size() == m_wl) begin
          e_valid = 1'b1;
          e_sum   = '0;
          foreach (m_hist[i]) e_sum += SUM_W'(m_hist[i]);
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("sum", sum_o, e_sum);
    check("valid", 32'(sum_valid_o), 32'(e_valid));
    check("full", 32'(full_o), 32'(m_hist.size() == m_wl));
    check("fill", 32'(fill_cnt_o), 32'(m_hist.size()));
  endtask

  // Driver: apply inputs, clock once, update the model, then compare.
  task automatic step(input int en, input int vld, input int clr, input int d);
    enable_i    = (en != 0);
    din_valid_i = (vld != 0);
    clear_i     = (clr != 0);
    din_i       = DIN_W'(d);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    if (sum_valid_o) pulses++;
  endtask

  task automatic restart(input int w);
    step(1, 0, 1, 0);
    window_width_i = PTR_W'(w);
    step(1, 0, 0, 0);
  endtask

  initial begin
    int exp_w4[6];
    int pt[3];
    int n;
    int v;
    exp_w4 = '{0, 0, 0, 10, 14, 18};
    pt     = '{7, 9, 3};

    reset_i        = 1'b1;
    clear_i        = 1'b0;
    enable_i       = 1'b0;
    din_valid_i    = 1'b0;
    din_i          = '0;
    window_width_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    check("reset_sum", sum_o, 0);
    reset_i = 1'b0;

    // W=4, samples 1..6 back-to-back
    window_width_i = 8'd4;
    step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0, i + 1);
      check("w4_pulse", 32'(sum_valid_o), 32'(i >= 3));
      if (i >= 3) check("w4_sum", sum_o, exp_w4[i]);
    end

    // W=0 and W=1 passthrough
    for (int w = 0; w < 2; w++) begin
      restart(w);
      for (int i = 0; i < 3; i++) begin
        step(1, 1, 0, pt[i]);
        check("pass_sum", sum_o, pt[i]);
      end
    end

    // W=255, 300 full-scale samples with random gaps
    restart(255);
    pulses = 0;
    n = 0;
    while (n < 300) begin
      v = ($urandom_range(0, 3) != 0) ? 1 : 0;
      step(1, v, 0, 16383);
      if (v != 0) n++;
      if (e_valid) check("max_sum", sum_o, 32'd4177665);
    end
    check("w255_pulses", pulses, 46);

    // W=3, clear together with a sample drops it
    restart(3);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 5);
    check("w3_sum", sum_o, 15);
    step(1, 1, 1, 9);
    check("clr_sum", sum_o, 0);
    check("clr_full", 32'(full_o), 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 1);
    step(1, 1, 0, 2);
    step(1, 1, 0, 3);
    check("refill_sum", sum_o, 6);

    // Width change in RUN is ignored until clear
    restart(4);
    for (int i = 0; i < 4; i++) step(1, 1, 0, $urandom_range(0, 16383));
    window_width_i = 8'd8;
    for (int i = 0; i < 6; i++) step(1, 1, 0, $urandom_range(0, 16383));
    check("w4_fill_hold", 32'(fill_cnt_o), 4);
    restart(8);
    for (int i = 0; i < 10; i++) step(1, 1, 0, $urandom_range(0, 16383));
    check("w8_fill", 32'(fill_cnt_o), 8);

    // Random widths with random enable/valid gaps
    for (int r = 0; r < 4; r++) begin
      restart($urandom_range(0, 20));
      for (int i = 0; i < 80; i++) begin
        step(($urandom_range(0, 9) < 8) ? 1 : 0,
             ($urandom_range(0, 9) < 7) ? 1 : 0, 0,
             $urandom_range(0, 16383));
      end
    end

    // Asynchronous reset in RUN
    restart(2);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 100 + i);
    #2;
    reset_i = 1'b1;
    #1;
    check("arst_sum", sum_o, 0);
    check("arst_valid", 32'(sum_valid_o), 0);
    check("arst_full", 32'(full_o), 0);
    check("arst_fill", 32'(fill_cnt_o), 0);
    model_reset();
    @(posedge clk);
    #1;
    check_outputs();
    reset_i = 1'b0;
    for (int i = 0; i < 3; i++) step(0, 1, 0, 5);
    step(1, 0, 0, 0);
    step(1, 1, 0, 4);
    check("post_rst_nopulse", 32'(sum_valid_o), 0);
    step(1, 1, 0, 6);
    check("post_rst_sum", sum_o, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
